// File: rtl/sdc_data_reader.sv
// SD 1-bit DAT0 single-block receiver: start-bit hunt, MSB-first byte
// assembly, CRC16-CCITT check of the received CRC and end bit.
module sdc_data_reader #(
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT     = 65535
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       sampleEn,
    input  logic       sdDat,
    output logic [7:0] dataOut,
    output logic       byteValid,
    output logic       blockDone,
    output logic       crcOk,
    output logic       crcErr,
    output logic       timeout,
    output logic       busy
);

    localparam int BITS = BLOCK_BYTES * 8;
    localparam int BW   = $clog2(BITS);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, DATA, CRC, ENDBIT, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bitCnt_q;
    logic [TW-1:0]   toCnt_q;
    logic [3:0]      crcCnt_q;
    logic [6:0]      shift_q;
    logic [15:0]     crcCalc_q, crcRx_q;
    logic            endBit_q;
    logic [7:0]      dataOut_q;
    logic            byteValid_q, blockDone_q;
    logic            crcOk_q, crcErr_q, timeout_q;

    logic            lastBit, toHit, crcFb;
    logic            byteValid_d, blockDone_d, matchOk;
    logic [15:0]     crcNext;

    assign lastBit = (bitCnt_q == BW'(BITS - 1));
    assign toHit   = (toCnt_q == TW'(TIMEOUT - 1));
    assign crcFb   = crcCalc_q[15] ^ sdDat;
    assign crcNext = {crcCalc_q[14:0], 1'b0}
                   ^ ({16{crcFb}} & 16'h1021);

    always_ff @(posedge clk) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start) state_d = WAIT_START;
            WAIT_START: if (sampleEn) begin
                            if (!sdDat)     state_d = DATA;
                            else if (toHit) state_d = DONE;
                        end
            DATA:       if (sampleEn && lastBit) state_d = CRC;
            CRC:        if (sampleEn && crcCnt_q == 4'd15)
                            state_d = ENDBIT;
            ENDBIT:     if (sampleEn) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        byteValid_d = (state_q == DATA) && sampleEn
                    && (bitCnt_q[2:0] == 3'd7);
        blockDone_d = (state_q == DONE);
        matchOk     = (crcRx_q == crcCalc_q) && endBit_q
                    && !timeout_q;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            bitCnt_q    <= '0;
            toCnt_q     <= '0;
            crcCnt_q    <= '0;
            shift_q     <= '0;
            crcCalc_q   <= '0;
            crcRx_q     <= '0;
            endBit_q    <= 1'b0;
            dataOut_q   <= '0;
            byteValid_q <= 1'b0;
            blockDone_q <= 1'b0;
            crcOk_q     <= 1'b0;
            crcErr_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            byteValid_q <= byteValid_d;
            blockDone_q <= blockDone_d;
            unique case (state_q)
                IDLE: if (start) begin
                    toCnt_q   <= '0;
                    crcCalc_q <= '0;
                    crcOk_q   <= 1'b0;
                    crcErr_q  <= 1'b0;
                    timeout_q <= 1'b0;
                end
                WAIT_START: if (sampleEn) begin
                    if (!sdDat) begin
                        bitCnt_q <= '0;
                    end else begin
                        toCnt_q <= toCnt_q + TW'(1);
                        if (toHit) timeout_q <= 1'b1;
                    end
                end
                DATA: if (sampleEn) begin
                    shift_q   <= {shift_q[5:0], sdDat};
                    crcCalc_q <= crcNext;
                    bitCnt_q  <= bitCnt_q + BW'(1);
                    if (byteValid_d) dataOut_q <= {shift_q, sdDat};
                    if (lastBit)     crcCnt_q  <= '0;
                end
                // computed CRC stays frozen while the card's CRC shifts in
                CRC: if (sampleEn) begin
                    crcRx_q  <= {crcRx_q[14:0], sdDat};
                    crcCnt_q <= crcCnt_q + 4'd1;
                end
                ENDBIT: if (sampleEn) endBit_q <= sdDat;
                DONE: begin
                    crcOk_q  <= matchOk;
                    crcErr_q <= !matchOk && !timeout_q;
                end
                default: ;
            endcase
        end
    end

    assign dataOut   = dataOut_q;
    assign byteValid = byteValid_q;
    assign blockDone = blockDone_q;
    assign crcOk     = crcOk_q;
    assign crcErr    = crcErr_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sdc_data_reader.sv
// Directed/randomized bench for sdc_data_reader with a polynomial-division
// CRC reference and a byte scoreboard.
module tb_sdc_data_reader;

    typedef logic [7:0] u8_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic       sampleEn = 1'b0;
    logic       sdDat = 1'b0;
    logic [7:0] dataOut;
    logic       byteValid, blockDone, crcOk, crcErr, timeout, busy;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  doneCnt = 0;
    int  doneCyc = 0;
    logic dOk = 1'b0, dErr = 1'b0, dTo = 1'b0;
    u8_t obsBytes[$];
    int  bvCyc[$];
    bit  stream[$];
    int  markIdx, markCyc, lastCyc;

    always #5 clk = ~clk;

    sdc_data_reader #(.BLOCK_BYTES(512), .TIMEOUT(100)) dut (
        .clk(clk), .resetN(resetN), .start(start),
        .sampleEn(sampleEn), .sdDat(sdDat),
        .dataOut(dataOut), .byteValid(byteValid),
        .blockDone(blockDone), .crcOk(crcOk), .crcErr(crcErr),
        .timeout(timeout), .busy(busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byteValid) begin
            obsBytes.push_back(dataOut);
            bvCyc.push_back(cyc);
        end
        if (blockDone) begin
            doneCnt <= doneCnt + 1;
            doneCyc <= cyc;
            dOk     <= crcOk;
            dErr    <= crcErr;
            dTo     <= timeout;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] ref_crc(input u8_t d[$]);
        logic [16:0] rem;
        logic        bv;
        rem = '0;
        for (int i = 0; i < d.size() + 2; i++) begin
            for (int b = 7; b >= 0; b--) begin
                bv = 1'b0;
                if (i < d.size()) bv = d[i][b];
                rem = {rem[15:0], bv};
                if (rem[16]) rem = rem ^ 17'h11021;
            end
        end
        return rem[15:0];
    endfunction

    task automatic build(input u8_t d[$], input logic [15:0] c,
                         input bit eb, input int pre);
        stream.delete();
        repeat (pre) stream.push_back(1'b1);
        stream.push_back(1'b0);
        foreach (d[i])
            for (int b = 7; b >= 0; b--) stream.push_back(d[i][b]);
        for (int b = 15; b >= 0; b--) stream.push_back(c[b]);
        stream.push_back(eb);
        markIdx = pre + 8;
    endtask

    task automatic arm();
        check("idle_not_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        check("flags_clear", 32'({crcOk, crcErr, timeout}), 32'd0);
    endtask

    task automatic play(input int from, input int to, input bit b2b);
        int gap;
        for (int i = from; i < to; i++) begin
            sampleEn = 1'b1;
            sdDat    = stream[i];
            if (i == markIdx) markCyc = cyc;
            lastCyc  = cyc;
            @(posedge clk); #1;
            sampleEn = 1'b0;
            sdDat    = 1'($urandom);
            gap = b2b ? 0 : int'($urandom_range(1, 0));
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic run_block(input string tag, input u8_t d[$],
                             input logic [15:0] c, input bit eb,
                             input bit b2b, input bit expOk);
        int base, dc, mism, badGap;
        base = obsBytes.size();
        dc   = doneCnt;
        build(d, c, eb, int'($urandom_range(20, 0)));
        arm();
        play(0, stream.size(), b2b);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check({tag, "_nbytes"}, 32'(obsBytes.size() - base),
              32'(d.size()));
        mism = 0;
        foreach (d[i])
            if (base + i >= obsBytes.size() ||
                obsBytes[base + i] !== d[i]) mism++;
        check({tag, "_data"}, 32'(mism), 32'd0);
        if (bvCyc.size() > base)
            check({tag, "_bv_lat"}, 32'(bvCyc[base] - markCyc), 32'd1);
        if (b2b) begin
            badGap = 0;
            for (int i = base + 1; i < bvCyc.size(); i++)
                if (bvCyc[i] - bvCyc[i-1] != 8) badGap++;
            check({tag, "_bv_spacing"}, 32'(badGap), 32'd0);
        end
        check({tag, "_done_cnt"}, 32'(doneCnt - dc), 32'd1);
        check({tag, "_done_lat"}, 32'(doneCyc - lastCyc), 32'd2);
        check({tag, "_ok"}, 32'(dOk), 32'(expOk));
        check({tag, "_err"}, 32'(dErr), 32'(!expOk));
        check({tag, "_to"}, 32'(dTo), 32'd0);
        check({tag, "_ok_hold"}, 32'(crcOk), 32'(expOk));
    endtask

    initial begin
        u8_t d[$];
        logic [15:0] c;
        int base, dc;

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst_outputs", 32'({dataOut, byteValid, blockDone, crcOk,
              crcErr, timeout, busy}), 32'd0);
        resetN = 1'b1;
        @(posedge clk); #1;

        d.delete();
        repeat (512) d.push_back(8'h00);
        run_block("zeros", d, 16'h0000, 1'b1, 1'b1, 1'b1);

        d.delete();
        repeat (512) d.push_back(8'hFF);
        run_block("ones", d, 16'h7FA1, 1'b1, 1'b0, 1'b1);

        d.delete();
        for (int i = 0; i < 512; i++) d.push_back(u8_t'(i));
        c = ref_crc(d) ^ (16'h1 << $urandom_range(15, 0));
        run_block("incr_badcrc", d, c, 1'b1, 1'b0, 1'b0);

        d.delete();
        repeat (512) d.push_back(u8_t'($urandom));
        run_block("endbit0", d, ref_crc(d), 1'b0, 1'b0, 1'b0);

        d.delete();
        repeat (512) d.push_back(u8_t'($urandom));
        run_block("rand_good", d, ref_crc(d), 1'b1, 1'b1, 1'b1);

        // start bit never arrives
        base = obsBytes.size();
        dc   = doneCnt;
        stream.delete();
        repeat (100) stream.push_back(1'b1);
        markIdx = -1;
        arm();
        play(0, 99, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("to_not_early", 32'(doneCnt - dc), 32'd0);
        play(99, 100, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("to_done_cnt", 32'(doneCnt - dc), 32'd1);
        check("to_done_lat", 32'(doneCyc - lastCyc), 32'd2);
        check("to_flag", 32'({dTo, dOk, dErr}), 32'b100);
        check("to_nbytes", 32'(obsBytes.size() - base), 32'd0);

        // abort mid-block with reset
        d.delete();
        repeat (512) d.push_back(u8_t'($urandom));
        base = obsBytes.size();
        dc   = doneCnt;
        build(d, ref_crc(d), 1'b1, 5);
        arm();
        play(0, 5 + 1 + 1600, 1'b0);
        @(posedge clk); #1;
        resetN = 1'b0;
        @(posedge clk); #1;
        check("abort_outputs", 32'({dataOut, byteValid, blockDone, crcOk,
              crcErr, timeout, busy}), 32'd0);
        resetN = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("abort_nbytes", 32'(obsBytes.size() - base), 32'd200);
        check("abort_no_done", 32'(doneCnt - dc), 32'd0);

        d.delete();
        repeat (512) d.push_back(u8_t'($urandom));
        run_block("after_rst", d, ref_crc(d), 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
